// File: rtl/fir_sched_ctrl_pkg.sv
// Shared types and constants for the 29-tap symmetric complex FIR.
//   Samp    : complex input sample (re/im, signed, Q2.22)
//   Coef    : coefficient value (signed)
//   NTAPS   : delay line depth (odd, symmetric filter)
//   NCOEF   : unique coefficients, (NTAPS+1)/2
//   phase_t : scheduler FSM states
//   tok_t   : one entry of the in-flight phase token pipe
package fir_sched_ctrl_pkg;

  localparam int SAMP_W = 24;
  localparam int COEF_W = 24;
  localparam int NTAPS  = 29;
  localparam int NCOEF  = (NTAPS + 1) / 2;

  typedef struct packed {
    logic signed [SAMP_W-1:0] re;
    logic signed [SAMP_W-1:0] im;
  } Samp;

  typedef logic signed [COEF_W-1:0] Coef;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    PH2  = 2'd3
  } phase_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] ph;
  } tok_t;

  // Datapath phase index carried on mux_sel; IDLE parks the mux at 0.
  function automatic logic [1:0] phase_sel(phase_t s);
    case (s)
      PH1:     return 2'd1;
      PH2:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fir_sched_ctrl_if.sv
// Bus between the FIR scheduler and its neighbours (sample source,
// coefficient writer, fir_datapath).
//   PushIn/StopIn/SampIn          : sample push/stop handshake
//   CoefWe/CoefAddr/CoefData      : coefficient write port
//   CoefErr                       : dropped-write pulse
//   samp/coef                     : delay line and coefficient bank to datapath
//   mux_sel, partialProductAccumulate_valid, finalAccumulateRounding_en : datapath control
//   busy                          : any phase in flight
// master = the surrounding system, slave = fir_sched_ctrl.
interface fir_sched_ctrl_if;
  import fir_sched_ctrl_pkg::*;

  logic              PushIn;
  logic              StopIn;
  Samp               SampIn;
  logic              CoefWe;
  logic [3:0]        CoefAddr;
  Coef               CoefData;
  logic              CoefErr;
  Samp [NTAPS-1:0]   samp;
  Coef [NCOEF-1:0]   coef;
  logic [1:0]        mux_sel;
  logic              partialProductAccumulate_valid;
  logic              finalAccumulateRounding_en;
  logic              busy;

  modport master (
    output PushIn, SampIn, CoefWe, CoefAddr, CoefData,
    input  StopIn, CoefErr, samp, coef, mux_sel,
           partialProductAccumulate_valid, finalAccumulateRounding_en, busy
  );

  modport slave (
    input  PushIn, SampIn, CoefWe, CoefAddr, CoefData,
    output StopIn, CoefErr, samp, coef, mux_sel,
           partialProductAccumulate_valid, finalAccumulateRounding_en, busy
  );

endinterface

// File: rtl/fir_sched_ctrl_delay_line.sv
// fir_sample_delay_line: NTAPS-deep complex sample shift register.
//   clk, reset : clock, async active-high reset (line zeroed)
//   shift_en   : shift in samp_in at this edge (samp[0] newest)
//   clear      : synchronous zero of the whole line, wins over shift_en
//   samp_in    : new sample
//   samp       : delay line contents
module fir_sample_delay_line
  import fir_sched_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            shift_en,
  input  logic            clear,
  input  Samp             samp_in,
  output Samp [NTAPS-1:0] samp
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp <= '0;
    end else if (clear) begin
      samp <= '0;
    end else if (shift_en) begin
      samp <= {samp[NTAPS-2:0], samp_in};
    end
  end

endmodule

// File: rtl/fir_sched_ctrl.sv
// fir_sched_ctrl: sequencer for the 29-tap symmetric complex FIR datapath
// (5 complex MACs x 3 phases). Accepts one sample per 3 cycles, owns the
// delay line and coefficient bank, and issues the datapath controls so
// each accepted sample produces exactly one final accumulate.
// Ports:
//   clk, reset : clock, async active-high reset
//   clear      : (only with FIR_SCHED_CLEAR_EN) synchronous flush of line,
//                FSM and token pipe; blocks accept that cycle
//   bus        : fir_sched_ctrl_if.slave (handshake, coef port, datapath side)
// Parameter MULT_LAT: complex multiplier latency, sum register to p_prod.
//
// state | meaning
// IDLE  | no phase issuing; samples accepted
// PH0   | phase 0 issued, mux_sel=0, input stalled
// PH1   | phase 1 issued, mux_sel=1, input stalled
// PH2   | phase 2 issued, mux_sel=2, next sample may be accepted
module fir_sched_ctrl
  import fir_sched_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef FIR_SCHED_CLEAR_EN
  input  logic clear,
`endif
  fir_sched_ctrl_if.slave bus
);

  // A phase token enters stage 0 at the sum register; stage MULT_LAT lines up
  // with p_prod valid, and the phase-0 token reaching the last stage marks the
  // cycle the third partial product has landed.
  localparam int TOK_DEPTH = 3 + MULT_LAT;

  phase_t                 state, state_nxt;
  tok_t [TOK_DEPTH-1:0]   tok;
  tok_t                   tok_in;
  logic                   clr;
  logic                   stop_in;
  logic                   issue;
  logic [1:0]             mux_sel;
  logic                   accept;
  logic                   pipe_busy;
  logic                   busy;
  logic                   coef_ok;
  logic                   coef_err;
  Coef [NCOEF-1:0]        coef;

`ifdef FIR_SCHED_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  assign accept = bus.PushIn & ~stop_in;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PH0;
      PH0:     state_nxt = PH1;
      PH1:     state_nxt = PH2;
      PH2:     state_nxt = accept ? PH0 : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // FSM: outputs
  always_comb begin
    mux_sel = phase_sel(state);
    stop_in = 1'b0;
    issue   = 1'b0;
    case (state)
      PH0: begin
        stop_in = 1'b1;
        issue   = 1'b1;
      end
      PH1: begin
        stop_in = 1'b1;
        issue   = 1'b1;
      end
      PH2: begin
        issue   = 1'b1;
      end
      default: ;
    endcase
    if (clr) stop_in = 1'b1;
  end

  assign tok_in.vld = issue;
  assign tok_in.ph  = mux_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok <= '0;
    end else if (clr) begin
      tok <= '0;
    end else begin
      tok <= {tok[TOK_DEPTH-2:0], tok_in};
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < TOK_DEPTH; i++) begin
      pipe_busy = pipe_busy | tok[i].vld;
    end
  end

  assign busy = (state != IDLE) | pipe_busy;

  // Coefficients may only change with nothing in flight and no sample
  // arriving, so the datapath never sees a bank change mid-sample.
  assign coef_ok = bus.CoefWe & ~busy & (bus.CoefAddr != 4'd15) & ~accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef     <= '0;
      coef_err <= 1'b0;
    end else begin
      coef_err <= bus.CoefWe & ~coef_ok;
      for (int k = 0; k < NCOEF; k++) begin
        if (coef_ok && (bus.CoefAddr == 4'(k))) begin
          coef[k] <= bus.CoefData;
        end
      end
    end
  end

  fir_sample_delay_line u_delay_line (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .clear    (clr),
    .samp_in  (bus.SampIn),
    .samp     (bus.samp)
  );

  assign bus.StopIn   = stop_in;
  assign bus.mux_sel  = mux_sel;
  assign bus.busy     = busy;
  assign bus.coef     = coef;
  assign bus.CoefErr  = coef_err;
  assign bus.partialProductAccumulate_valid =
    tok[MULT_LAT].vld & (tok[MULT_LAT].ph != 2'd0);
  assign bus.finalAccumulateRounding_en =
    tok[TOK_DEPTH-1].vld & (tok[TOK_DEPTH-1].ph == 2'd0);

endmodule
